// File: rtl/wb_sdram_arbiter_pkg.sv
// ----------------------------------------------------------------------------
// wb_sdram_arbiter_pkg
// Shared definitions for the two-master Wishbone arbiter in front of the
// SDRAM bridge: FSM state encodings, grant identifiers and a small helper
// that maps a grant id onto its bus-owning state.
// No ports; imported by wb_sdram_arbiter and wb_arb_rr_pick.
// ----------------------------------------------------------------------------
package wb_sdram_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_BUS0    = 2'd1,
        ST_BUS1    = 2'd2,
        ST_RELEASE = 2'd3
    } arb_state_e;

    localparam logic GNT_M0 = 1'b0;
    localparam logic GNT_M1 = 1'b1;

    function automatic arb_state_e bus_state(input logic gnt_id);
        return (gnt_id == GNT_M1) ? ST_BUS1 : ST_BUS0;
    endfunction

endpackage

// File: rtl/wb_sdram_arbiter_rr_pick.sv
// ----------------------------------------------------------------------------
// wb_arb_rr_pick
// Combinational two-way round-robin picker. A lone request always wins; on a
// tie the master that did not win last time is picked.
// Ports:
//   req0_i      master 0 request
//   req1_i      master 1 request
//   last_i      id of the most recently granted master
//   gnt_valid_o at least one request present
//   gnt_id_o    id of the master to grant (meaningful with gnt_valid_o)
// ----------------------------------------------------------------------------
module wb_arb_rr_pick
    import wb_sdram_arbiter_pkg::*;
(
    input  logic req0_i,
    input  logic req1_i,
    input  logic last_i,
    output logic gnt_valid_o,
    output logic gnt_id_o
);

    always_comb begin
        gnt_valid_o = req0_i | req1_i;
        if (req0_i && req1_i) begin
            gnt_id_o = (last_i == GNT_M1) ? GNT_M0 : GNT_M1;
        end else if (req1_i) begin
            gnt_id_o = GNT_M1;
        end else begin
            gnt_id_o = GNT_M0;
        end
    end

endmodule

// File: rtl/wb_sdram_arbiter.sv
// ----------------------------------------------------------------------------
// wb_sdram_arbiter
// Two-master Wishbone arbiter feeding the single 32-bit Wishbone-to-16-bit
// Avalon SDRAM bridge. Master 0 is the instruction bus, master 1 the data bus.
// One master is locked onto the bridge until the bridge acks; the bridge's
// possibly multi-cycle ack is reduced to a single-cycle ack to that master,
// and the tail of the ack is absorbed in RELEASE. Ties alternate round-robin.
//
// Optional feature: define WB_ARB_TIMEOUT_EN to add a bus watchdog. After
// TIMEOUT cycles in a bus state without an ack, the owning master receives a
// 1-cycle err instead of an ack and the arbiter releases the bridge.
// Without the macro mN_err_o is tied low and a bus state waits forever.
//
// Ports:
//   clk, rst               clock, synchronous active-high reset
//   mN_adr_i/dat_i/sel_i   master N address, write data, byte selects
//   mN_we_i/cyc_i/stb_i    master N write enable, cycle, strobe
//   mN_dat_o               read data to master N (bridge data fanned out)
//   mN_ack_o/err_o         1-cycle ack / timeout error to master N
//   s_adr_o/dat_o/sel_o    bridge address, write data, byte selects
//   s_we_o/cyc_o/stb_o     bridge write enable, cycle, strobe
//   s_dat_i/ack_i          bridge read data, ack (may be held several cycles)
// ----------------------------------------------------------------------------
module wb_sdram_arbiter
    import wb_sdram_arbiter_pkg::*;
#(
    parameter int AW      = 32,
    parameter int DW      = 32,
    parameter int TIMEOUT = 1024
) (
    input  logic            clk,
    input  logic            rst,

    input  logic [AW-1:0]   m0_adr_i,
    input  logic [DW-1:0]   m0_dat_i,
    input  logic [DW/8-1:0] m0_sel_i,
    input  logic            m0_we_i,
    input  logic            m0_cyc_i,
    input  logic            m0_stb_i,
    output logic [DW-1:0]   m0_dat_o,
    output logic            m0_ack_o,
    output logic            m0_err_o,

    input  logic [AW-1:0]   m1_adr_i,
    input  logic [DW-1:0]   m1_dat_i,
    input  logic [DW/8-1:0] m1_sel_i,
    input  logic            m1_we_i,
    input  logic            m1_cyc_i,
    input  logic            m1_stb_i,
    output logic [DW-1:0]   m1_dat_o,
    output logic            m1_ack_o,
    output logic            m1_err_o,

    output logic [AW-1:0]   s_adr_o,
    output logic [DW-1:0]   s_dat_o,
    output logic [DW/8-1:0] s_sel_o,
    output logic            s_we_o,
    output logic            s_cyc_o,
    output logic            s_stb_o,
    input  logic [DW-1:0]   s_dat_i,
    input  logic            s_ack_i
);

    arb_state_e state_q;
    logic       last_q;
    logic       gnt_valid;
    logic       gnt_id;
    logic       in_bus;
    logic       expire;

    wb_arb_rr_pick u_pick (
        .req0_i      (m0_cyc_i & m0_stb_i),
        .req1_i      (m1_cyc_i & m1_stb_i),
        .last_i      (last_q),
        .gnt_valid_o (gnt_valid),
        .gnt_id_o    (gnt_id)
    );

    assign in_bus = (state_q == ST_BUS0) || (state_q == ST_BUS1);

`ifdef WB_ARB_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT);
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

    logic [CW-1:0] cnt_q;

    // Counts cycles spent in the current bus state; cleared on every grant.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else if (state_q == ST_IDLE) begin
            cnt_q <= '0;
        end else if (in_bus) begin
            cnt_q <= cnt_q + CW'(1);
        end
    end

    assign expire = in_bus && (cnt_q == CNT_LAST);
`else
    logic unused_timeout;
    assign unused_timeout = (TIMEOUT < 2);
    assign expire         = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            last_q  <= GNT_M1;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (gnt_valid) begin
                        state_q <= bus_state(gnt_id);
                        last_q  <= gnt_id;
                    end
                end
                ST_BUS0, ST_BUS1: begin
                    // Grant stays locked until the bridge answers (or the
                    // watchdog fires), whatever the master does meanwhile.
                    if (s_ack_i || expire) begin
                        state_q <= ST_RELEASE;
                    end
                end
                ST_RELEASE: begin
                    // Swallow the remainder of a stretched bridge ack.
                    if (!s_ack_i) begin
                        state_q <= ST_IDLE;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    always_comb begin
        s_adr_o = '0;
        s_dat_o = '0;
        s_sel_o = '0;
        s_we_o  = 1'b0;
        case (state_q)
            ST_BUS0: begin
                s_adr_o = m0_adr_i;
                s_dat_o = m0_dat_i;
                s_sel_o = m0_sel_i;
                s_we_o  = m0_we_i;
            end
            ST_BUS1: begin
                s_adr_o = m1_adr_i;
                s_dat_o = m1_dat_i;
                s_sel_o = m1_sel_i;
                s_we_o  = m1_we_i;
            end
            default: ;
        endcase
    end

    assign s_cyc_o = in_bus;
    assign s_stb_o = in_bus;

    // Ack/err are only ever raised in the single cycle that leaves a bus
    // state, so each is exactly one cycle wide. A reset cycle suppresses
    // them because the transfer is being abandoned.
    assign m0_ack_o = !rst && (state_q == ST_BUS0) && s_ack_i;
    assign m1_ack_o = !rst && (state_q == ST_BUS1) && s_ack_i;
    assign m0_err_o = !rst && (state_q == ST_BUS0) && expire && !s_ack_i;
    assign m1_err_o = !rst && (state_q == ST_BUS1) && expire && !s_ack_i;

    assign m0_dat_o = s_dat_i;
    assign m1_dat_o = s_dat_i;

endmodule
